// File: rtl/seq_alu.sv
// Registered sequential ALU: single-cycle logic/add/shift ops, iterative shift-add MULT and restoring DIV.
// Define SEQ_ALU_ACC_EN to build the internal accumulator (ops ACC/CLRACC); otherwise acc is tied to 0.
module seq_alu #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           cmd,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 overflow,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     acc
);

    localparam int unsigned RW = 2 * WIDTH;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MULT   = 4'd2;
    localparam logic [3:0] OP_DIV    = 4'd3;
    localparam logic [3:0] OP_SLL    = 4'd4;
    localparam logic [3:0] OP_SRL    = 4'd5;
    localparam logic [3:0] OP_AND    = 4'd6;
    localparam logic [3:0] OP_OR     = 4'd7;
    localparam logic [3:0] OP_XOR    = 4'd8;
    localparam logic [3:0] OP_NOT    = 4'd9;
    localparam logic [3:0] OP_NAND   = 4'd10;
    localparam logic [3:0] OP_NOR    = 4'd11;
`ifdef SEQ_ALU_ACC_EN
    localparam logic [3:0] OP_ACC    = 4'd12;
    localparam logic [3:0] OP_CLRACC = 4'd13;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNTW-1:0]   cnt;
    logic              is_div;

    // Iterative datapath working registers
    logic [RW-1:0]     prod;
    logic [RW-1:0]     mcand;
    logic [WIDTH-1:0]  mplr;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  divisor;

    logic [RW-1:0]     sc_result;
    logic              sc_ovf;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  diff;
    logic [WIDTH-1:0]  lo;
    logic [RW-1:0]     mul_sum;
    logic [WIDTH:0]    shifted;
    logic              div_ge;
    logic [WIDTH-1:0]  rem_next;
    logic [WIDTH-1:0]  quo_next;

`ifdef SEQ_ALU_ACC_EN
    logic [WIDTH:0]    acc_sum;
    logic              acc_we;
    logic [WIDTH-1:0]  acc_d;
`endif

    // Single-cycle operation results, evaluated on the live operands at the accept edge
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        lo        = '0;
        sum       = {1'b0, a} + {1'b0, b};
        diff      = a - b;
`ifdef SEQ_ALU_ACC_EN
        acc_sum   = {1'b0, acc} + {1'b0, a};
        acc_we    = 1'b0;
        acc_d     = acc;
`endif
        case (cmd)
            OP_ADD: begin
                sc_result = RW'(sum);
                sc_ovf    = sum[WIDTH];
            end
            OP_SUB: begin
                lo        = diff;
                sc_result = {{WIDTH{1'b0}}, lo};
                sc_ovf    = (a < b);
            end
            OP_SLL:  sc_result = {{WIDTH{1'b0}}, a} << b;
            OP_SRL: begin
                lo        = a >> b;
                sc_result = {{WIDTH{1'b0}}, lo};
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR: begin
                case (cmd)
                    OP_AND:  lo = a & b;
                    OP_OR:   lo = a | b;
                    OP_XOR:  lo = a ^ b;
                    OP_NOT:  lo = ~a;
                    OP_NAND: lo = ~(a & b);
                    default: lo = ~(a | b);
                endcase
                sc_result = {{WIDTH{1'b0}}, lo};
            end
`ifdef SEQ_ALU_ACC_EN
            OP_ACC: begin
                acc_we    = 1'b1;
                acc_d     = acc_sum[WIDTH-1:0];
                sc_result = {{WIDTH{1'b0}}, acc_sum[WIDTH-1:0]};
                sc_ovf    = acc_sum[WIDTH];
            end
            OP_CLRACC: begin
                acc_we    = 1'b1;
                acc_d     = '0;
            end
`endif
            default: begin
                sc_result = '0;
                sc_ovf    = 1'b0;
            end
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum  = prod + (mplr[0] ? mcand : '0);
        shifted  = {rem, quo[WIDTH-1]};
        div_ge   = (shifted >= {1'b0, divisor});
        rem_next = div_ge ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], div_ge};
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            is_div      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            prod        <= '0;
            mcand       <= '0;
            mplr        <= '0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        cnt  <= '0;
                        if (cmd == OP_MULT) begin
                            is_div <= 1'b0;
                            prod   <= '0;
                            mcand  <= RW'(a);
                            mplr   <= b;
                            state  <= S_EXEC;
                        end else if (cmd == OP_DIV) begin
                            is_div  <= 1'b1;
                            rem     <= '0;
                            quo     <= a;
                            divisor <= b;
                            state   <= S_EXEC;
                        end else begin
                            result      <= sc_result;
                            overflow    <= sc_ovf;
                            div_by_zero <= 1'b0;
                            state       <= S_DONE;
                        end
                    end
                end
                S_EXEC: begin
                    if (is_div) begin
                        rem <= rem_next;
                        quo <= quo_next;
                    end else begin
                        prod  <= mul_sum;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                    end
                    if (cnt == CNTW'(WIDTH - 1)) begin
                        // A zero divisor naturally yields quotient all-ones and remainder a
                        result      <= is_div ? {rem_next, quo_next} : mul_sum;
                        overflow    <= 1'b0;
                        div_by_zero <= is_div && (divisor == '0);
                        state       <= S_DONE;
                    end else begin
                        cnt <= cnt + CNTW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_ALU_ACC_EN
    // Accumulator changes only on an accepted ACC/CLRACC or reset
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (state == S_IDLE && start && acc_we) begin
            acc <= acc_d;
        end
    end
`else
    assign acc = '0;
`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU.
- Accepts one operation per start/done handshake.
- Single-cycle logic, add and shift ops; iterative multiply (shift-add) and divide (restoring), each taking WIDTH cycles.
- Optional internal accumulator.
- Sits between the operand registers and the control decoder; the next generation of the 16-bit combinational ALU.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2 to 32.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- cmd  input  4  opcode; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high from accept through the done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- result  output  2*WIDTH  result; held until the next completion.
- overflow  output  1  carry/borrow flag; updated at completion.
- div_by_zero  output  1  set when DIV completes with b==0.
- acc  output  WIDTH  accumulator value; 0 when ACC_EN is not defined.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy, done, result, overflow, div_by_zero, acc, counter all 0.
  - Applies mid-operation too: any operation in flight is aborted and no done is issued.
- States: IDLE, EXEC, DONE.
  - IDLE, start=1, single-cycle op: result and flags are loaded at the sampling edge; go to DONE.
  - IDLE, start=1, MULT or DIV: operands are latched; counter=0; go to EXEC.
  - EXEC: one iteration per cycle. At the edge where counter reaches WIDTH-1, result and flags are loaded; go to DONE.
  - DONE: done=1, busy=1 for exactly one cycle; then IDLE.
- Latency: start sampled at edge k.
  - Single-cycle ops: done visible after edge k+1.
  - MULT/DIV: done visible after edge k+WIDTH+1.
- start while busy, including during the DONE cycle, is ignored and not queued.
- Back-to-back throughput is one operation per 2 cycles (single-cycle ops).
- Opcodes, with result zero-extended to 2*WIDTH unless stated:
  - 0 ADD: result = a+b on WIDTH+1 bits; overflow = carry out.
  - 1 SUB: result low WIDTH bits = (a-b) mod 2^WIDTH; overflow = (a<b).
  - 2 MULT: full unsigned 2*WIDTH product; overflow=0.
  - 3 DIV: result = {remainder, quotient}, unsigned.
    - b==0: quotient = all ones, remainder = a, div_by_zero=1.
  - 4 SLL: zero-extended a shifted left by b; b >= 2*WIDTH gives 0.
  - 5 SRL: a >> b; b >= WIDTH gives 0.
  - 6 AND, 7 OR, 8 XOR, 10 NAND, 11 NOR: bitwise on WIDTH bits.
  - 9 NOT: ~a on WIDTH bits; b ignored.
  - 12 ACC, 13 CLRACC: see Optional Feature.
  - 14, 15: illegal; result=0, overflow=0, div_by_zero=0, done still pulses.
- Flags:
  - overflow and div_by_zero are rewritten at every completion.
  - Each flag is 0 unless its opcode sets it.
- Operand inputs may change after the accept edge without affecting the operation in flight.

Optional Feature:
- Macro: SEQ_ALU_ACC_EN.
- Defined:
  - WIDTH-bit accumulator register.
  - Op 12 ACC: acc <= acc + a mod 2^WIDTH; overflow = carry out; result = zero-extended new acc. Single-cycle.
  - Op 13 CLRACC: acc <= 0; result=0; overflow=0.
  - acc is cleared only by reset or CLRACC.
- Not defined:
  - No accumulator register; acc output tied to 0.
  - Ops 12 and 13 behave as illegal opcodes.

Test Plan:
- ADD a=16'hFFFF, b=16'h0001 -> done after 1 cycle; result=32'h0001_0000; overflow=1.
- MULT a=16'h1234, b=16'h0100 -> busy for 17 cycles, done on 17th; result=32'h0012_3400. A second start with cmd=ADD, pulsed at cycle 5, is ignored.
- DIV a=100, b=7 -> result=32'h0002_000E after WIDTH+1 cycles. DIV a=5, b=0 -> result=32'h0005_FFFF; div_by_zero=1. A following AND clears div_by_zero.
- SUB a=3, b=5 -> result=32'h0000_FFFE; overflow=1. SLL a=16'h8001, b=4 -> 32'h0008_0010. SRL b=20 -> 0.
- Reset pulse (rst=0) at cycle 8 of a MULT -> all outputs 0 immediately, no done. A new ADD 2+3 accepted after release -> result 5.
- With SEQ_ALU_ACC_EN: ACC a=16'hFFF0 twice -> acc=16'hFFE0, overflow=1 on the second; CLRACC -> acc=0. Without the macro: op 12 -> result 0, acc stays 0.
